// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the 4-digit 7-segment scanner.
//   NUM_DIGITS / SEG_W : display geometry (4 digits, {dp,g..a} segment bus)
//   digit_t            : index of the digit slot being scanned
//   segOffFor/anOffFor : "all unlit" / "all anodes inactive" bus values for a
//                        given output polarity; the top derives its SEG_OFF and
//                        AN_OFF constants from these.
// Optional feature macro used by the design: SEG_SCANNER_DIM_EN
// ---------------------------------------------------------------------------
package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEG_W      = 8;

  typedef logic [1:0] digit_t;

  // Idle value of the segment bus: every segment dark.
  function automatic logic [SEG_W-1:0] segOffFor(input bit activeLow);
    return activeLow ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
  endfunction

  // Idle value of the anode lines: every digit disabled.
  function automatic logic [NUM_DIGITS-1:0] anOffFor(input bit activeLow);
    return activeLow ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  endfunction

endpackage

// File: rtl/seg_scan_prescaler.sv
// ---------------------------------------------------------------------------
// seg_scan_prescaler
// Slot timebase for the scanner: cnt runs 0..CLK_DIV-1 inside each digit
// slot, and digit steps 0..3 each time cnt wraps. Dropping en parks both
// counters at zero so the next enabled cycle is again the start of slot 0.
// Ports:
//   clk_i, reset_i : clock, asynchronous active-high reset
//   en_i           : scan enable
//   digit_o        : current slot index
//   blank_o        : high for the first BLANK_CYCLES cycles of a slot
//   frameStart_o   : high on the cycle that begins slot 0 while enabled
// ---------------------------------------------------------------------------
module seg_scan_prescaler
  import seg_pkg::*;
#(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic   clk_i,
  input  logic   reset_i,
  input  logic   en_i,
  output digit_t digit_o,
  output logic   blank_o,
  output logic   frameStart_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  digit_t        digit_q, digit_d;

  // Next-state of the slot counter and digit index; en low forces both to
  // zero so re-enabling always begins with a fresh frame.
  always_comb begin
    cnt_d   = cnt_q;
    digit_d = digit_q;
    if (!en_i) begin
      cnt_d   = '0;
      digit_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      digit_d = digit_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      digit_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
    end
  end

  assign digit_o      = digit_q;
  assign blank_o      = (cnt_q < BLANK_LIM);
  assign frameStart_o = en_i && (cnt_q == '0) && (digit_q == '0);

endmodule

// File: rtl/seg_scanner.sv
// ---------------------------------------------------------------------------
// seg_scanner
// Time-multiplexed driver for a 4-digit 7-segment display with decimal point.
// One coherent 32-bit frame is captured at the start of slot 0 and then shown
// digit by digit; each slot begins with BLANK_CYCLES cycles of all anodes off
// to stop the previous digit's pattern ghosting onto the next one.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   en         : scan enable
//   segs[31:0] : byte i = digit i pattern {dp,g..a}, active-high
//   bright[3:0]: brightness, only with SEG_SCANNER_DIM_EN defined
//   an[3:0]    : digit enables (ACTIVE_LOW_AN polarity), registered
//   seg[7:0]   : segment bus (ACTIVE_LOW_SEG polarity), registered
//   digit[1:0] : slot currently being scanned
//   frame_stb  : one-cycle pulse when a frame is latched
// Optional feature macro: SEG_SCANNER_DIM_EN (PWM dimming of the anodes).
// ---------------------------------------------------------------------------
module seg_scanner
  import seg_pkg::*;
#(
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter int ACTIVE_LOW_AN  = 1,
  parameter int ACTIVE_LOW_SEG = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic [NUM_DIGITS*SEG_W-1:0] segs,
`ifdef SEG_SCANNER_DIM_EN
  input  logic [3:0]                  bright,
`endif
  output logic [NUM_DIGITS-1:0]       an,
  output logic [SEG_W-1:0]            seg,
  output logic [1:0]                  digit,
  output logic                        frame_stb
);

  localparam logic [SEG_W-1:0]      SEG_OFF = segOffFor(ACTIVE_LOW_SEG != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = anOffFor(ACTIVE_LOW_AN != 0);

  digit_t digitCur;
  logic   blank;
  logic   frameStart;

  logic [NUM_DIGITS*SEG_W-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]       an_q, an_d;
  logic [SEG_W-1:0]            seg_q, seg_d;
  logic                        stb_q, stb_d;
  logic [SEG_W-1:0]            slotByte;
  logic [NUM_DIGITS-1:0]       anOneHot;
  logic                        lit;

`ifdef SEG_SCANNER_DIM_EN
  logic [3:0] bright_q, bright_d;
  logic [3:0] pwm_q;
`endif

  seg_scan_prescaler #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_prescaler (
    .clk_i        (clk),
    .reset_i      (reset),
    .en_i         (en),
    .digit_o      (digitCur),
    .blank_o      (blank),
    .frameStart_o (frameStart)
  );

  // Frame capture and output mux. The byte is read from shadow_d rather than
  // shadow_q so that a zero-blank configuration still shows the newly latched
  // frame on the very first cycle of slot 0.
  always_comb begin
    shadow_d = frameStart ? segs : shadow_q;
    slotByte = shadow_d[{digitCur, 3'b000} +: SEG_W];
    anOneHot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << digitCur;
    stb_d    = frameStart;
    lit      = en && !blank;
`ifdef SEG_SCANNER_DIM_EN
    bright_d = frameStart ? bright : bright_q;
`endif
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (lit) begin
      seg_d = (ACTIVE_LOW_SEG != 0) ? ~slotByte : slotByte;
`ifdef SEG_SCANNER_DIM_EN
      if (pwm_q <= bright_d) begin
        an_d = (ACTIVE_LOW_AN != 0) ? ~anOneHot : anOneHot;
      end
`else
      an_d = (ACTIVE_LOW_AN != 0) ? ~anOneHot : anOneHot;
`endif
    end
  end

  // Shadow frame and registered board outputs; reset drives the pins to
  // their idle levels without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      stb_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      stb_q    <= stb_d;
    end
  end

`ifdef SEG_SCANNER_DIM_EN
  // Free-running PWM phase plus the brightness value captured with the frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_q    <= '0;
      bright_q <= '0;
    end else begin
      pwm_q    <= pwm_q + 4'd1;
      bright_q <= bright_d;
    end
  end
`endif

  assign an        = an_q;
  assign seg       = seg_q;
  assign digit     = digitCur;
  assign frame_stb = stb_q;

endmodule

// File: tb/tb_seg_scanner.sv
// ---------------------------------------------------------------------------
// tb_seg_scanner
// Scoreboard bench for seg_scanner with CLK_DIV=8, BLANK_CYCLES=2 and
// active-low anodes and segments. The stimulus task pushes the expected
// {an, seg, digit, frame_stb} for every clock into a queue; the monitor pops
// and compares at each falling edge, and also watches that no more than one
// anode is ever active. Honours SEG_SCANNER_DIM_EN by tying bright to 15,
// which must give the same waveform as the plain build.
// ---------------------------------------------------------------------------
module tb_seg_scanner;

  localparam int CLK_DIV = 8;
  localparam int BLANK   = 2;
  localparam int FRAME   = 4 * CLK_DIV;

  // Digit 0 is the low byte: 4F, 5B, 06, 3F.
  localparam logic [31:0] FRAME_A = 32'h3F065B4F;
  // Hand-inverted bus values, digit 0 in the low byte: B0, A4, F9, C0.
  localparam logic [31:0] TBL_A   = {8'hC0, 8'hF9, 8'hA4, 8'hB0};
  localparam logic [31:0] TBL_OFF = 32'hFFFF_FFFF;
  // Active-low anode pattern per digit, digit 0 in the low nibble.
  localparam logic [15:0] AN_TBL  = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    logic [1:0] digit;
    logic       stb;
    int         scen;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [31:0] segs = '0;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [1:0]  digit;
  logic        frame_stb;
`ifdef SEG_SCANNER_DIM_EN
  logic [3:0]  bright = 4'hF;
`endif

  exp_t        sb[$];
  exp_t        monE;
  exp_t        asyncE;
  int          total = 0;
  int          bad = 0;
  int          scen = 0;
  int          runN = 0;
  int          cycNo = 0;
  logic [31:0] tblLatched = '1;
  logic        probe = 1'b0;

  always #5 clk = ~clk;

  seg_scanner #(
    .CLK_DIV        (CLK_DIV),
    .BLANK_CYCLES   (BLANK),
    .ACTIVE_LOW_AN  (1),
    .ACTIVE_LOW_SEG (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .segs      (segs),
`ifdef SEG_SCANNER_DIM_EN
    .bright    (bright),
`endif
    .an        (an),
    .seg       (seg),
    .digit     (digit),
    .frame_stb (frame_stb)
  );

  // One comparison: bumps the totals and reports a mismatch on one line.
  task automatic checkOutput(input string name, input int sc, input int cy,
                             input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s scen=%0d cyc=%0d got=%0h want=%0h", name, sc, cy, act, want);
    end
  endtask

  // Drives en/segs for a number of clocks and queues the expected outputs
  // after each edge. runN counts enabled edges since the last reset or en
  // drop, so runN mod 32 is the (slot, cnt) position before the edge; tbl is
  // the hand-computed bus value of the frame offered with segsV.
  task automatic applyStimulus(input logic enV, input logic [31:0] segsV,
                               input logic [31:0] tbl, input int cycles);
    exp_t        e;
    int          pos;
    logic [15:0] anTbl;
    anTbl = AN_TBL;
    for (int i = 0; i < cycles; i++) begin
      en   = enV;
      segs = segsV;
      @(posedge clk);
      #1;
      cycNo++;
      e.scen  = scen;
      e.cyc   = cycNo;
      e.an    = 4'hF;
      e.seg   = 8'hFF;
      e.digit = 2'd0;
      e.stb   = 1'b0;
      if (reset || !enV) begin
        runN = 0;
      end else begin
        pos = runN % FRAME;
        if (pos == 0) tblLatched = tbl;
        e.stb   = (pos == 0);
        e.digit = 2'(((pos + 1) % FRAME) / CLK_DIV);
        if ((pos % CLK_DIV) >= BLANK) begin
          e.an  = anTbl[(pos / CLK_DIV) * 4 +: 4];
          e.seg = tblLatched[(pos / CLK_DIV) * 8 +: 8];
        end
        runN++;
      end
      sb.push_back(e);
    end
  endtask

  // Monitor: compares queued expectations at every falling edge (or when the
  // stimulus raises probe between edges) and checks the one-anode rule.
  initial begin
    forever begin
      @(negedge clk or posedge probe);
      if (sb.size() > 0) begin
        monE = sb.pop_front();
        checkOutput("an", monE.scen, monE.cyc, 32'(an), 32'(monE.an));
        checkOutput("seg", monE.scen, monE.cyc, 32'(seg), 32'(monE.seg));
        checkOutput("digit", monE.scen, monE.cyc, 32'(digit), 32'(monE.digit));
        checkOutput("frame_stb", monE.scen, monE.cyc, 32'(frame_stb), 32'(monE.stb));
      end
      checkOutput("an_at_most_one", scen, cycNo, 32'($countones(~an) <= 1), 32'd1);
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog scen=%0d got=timeout want=finish", scen);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] seg_scanner scoreboard bench starting");
    #1 reset = 1'b1;

    // Reset held with a frame and en present: pins stay idle.
    scen = 1;
    applyStimulus(1'b1, FRAME_A, TBL_A, 4);
    reset = 1'b0;

    // First frame: latch and strobe on edge 1, then four lit slots.
    scen = 2;
    applyStimulus(1'b1, FRAME_A, TBL_A, 12);

    // segs cleared mid-slot 1: rest of frame unchanged, next frame all dark.
    scen = 3;
    applyStimulus(1'b1, 32'h0000_0000, TBL_OFF, 20);
    applyStimulus(1'b1, 32'h0000_0000, TBL_OFF, FRAME);

    // en dropped for 5 cycles during slot 2, then re-asserted.
    scen = 4;
    applyStimulus(1'b1, FRAME_A, TBL_A, 19);
    applyStimulus(1'b0, FRAME_A, TBL_A, 5);
    applyStimulus(1'b1, FRAME_A, TBL_A, FRAME * 28 + 20);

    // Asynchronous reset in the middle of slot 2, checked before any edge.
    scen = 5;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    asyncE.an    = 4'hF;
    asyncE.seg   = 8'hFF;
    asyncE.digit = 2'd0;
    asyncE.stb   = 1'b0;
    asyncE.scen  = scen;
    asyncE.cyc   = cycNo;
    sb.push_back(asyncE);
    probe = 1'b1;
    #1 probe = 1'b0;
    applyStimulus(1'b1, FRAME_A, TBL_A, 3);

    repeat (2) @(negedge clk);
    #1;
    if (sb.size() != 0) checkOutput("scoreboard_drained", scen, cycNo, 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
